csa_mw_add_arbiter: RTL

//   Shares one combinational WIDTH-bit carry-select adder (the csa_<N>bit family, carry-in exposed)

---
 rtl/csa_mw_add_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/csa_mw_add_arbiter.sv
// Two-requester front end for one shared WIDTH-bit adder: multi-word add, one word per cycle,
// LSW first, carry chained through a register, round-robin between simultaneous requesters.
module csa_mw_add_arbiter #(
   parameter int WIDTH  = 46,
   parameter int NWORDS = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic [1:0]               i_req_valid,
   output logic [1:0]               o_req_ready,
   input  logic [NWORDS*WIDTH-1:0]  i_op_a0,
   input  logic [NWORDS*WIDTH-1:0]  i_op_b0,
   input  logic [NWORDS*WIDTH-1:0]  i_op_a1,
   input  logic [NWORDS*WIDTH-1:0]  i_op_b1,
   output logic                     o_rsp_valid,
   input  logic                     i_rsp_ready,
   output logic [NWORDS*WIDTH-1:0]  o_rsp_sum,
   output logic                     o_rsp_cout,
   output logic                     o_rsp_id,
   output logic [WIDTH-1:0]         o_add_a,
   output logic [WIDTH-1:0]         o_add_b,
   output logic                     o_add_cin,
   input  logic [WIDTH-1:0]         i_add_sum,
   input  logic                     i_add_cout,
   output logic                     o_busy
);

   localparam int TW = NWORDS * WIDTH;
   localparam int KW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   logic [KW-1:0]   r_k;
   logic            r_carry;
   logic            r_rr;
   logic            r_id;
   logic            r_cout;
   logic [TW-1:0]   r_a;
   logic [TW-1:0]   r_b;
   logic [TW-1:0]   r_sum;

   logic            w_idle;
   logic            w_run;
   logic            w_grant;
   logic            w_accept;
   logic            w_last;

   // Handshakes: a request transfers on the edge where i_req_valid[r] & o_req_ready[r];
   // a result transfers on the edge where o_rsp_valid & i_rsp_ready.
   assign w_idle   = (r_state == S_IDLE);
   assign w_run    = (r_state == S_RUN);
   assign w_grant  = (&i_req_valid) ? r_rr : i_req_valid[1];
   assign w_accept = |(o_req_ready & i_req_valid);
   assign w_last   = (r_k == KW'(NWORDS - 1));

   assign o_req_ready[0] = w_idle & i_req_valid[0] & ~w_grant;
   assign o_req_ready[1] = w_idle & i_req_valid[1] & w_grant;

   assign o_add_a   = w_run ? r_a[r_k*WIDTH +: WIDTH] : '0;
   assign o_add_b   = w_run ? r_b[r_k*WIDTH +: WIDTH] : '0;
   assign o_add_cin = w_run & r_carry;

   assign o_rsp_valid = (r_state == S_DONE);
   assign o_rsp_sum   = r_sum;
   assign o_rsp_cout  = r_cout;
   assign o_rsp_id    = r_id;
   assign o_busy      = ~w_idle;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_k     <= '0;
         r_carry <= 1'b0;
         r_rr    <= 1'b0;
         r_id    <= 1'b0;
         r_cout  <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_a     <= w_grant ? i_op_a1 : i_op_a0;
                  r_b     <= w_grant ? i_op_b1 : i_op_b0;
                  r_id    <= w_grant;
                  r_k     <= '0;
                  r_carry <= 1'b0;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_sum[r_k*WIDTH +: WIDTH] <= i_add_sum;
               r_carry <= i_add_cout;
               r_k     <= r_k + 1'b1;
               if (w_last) begin
                  r_cout  <= i_add_cout;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               // The requester just served loses priority on the next tie.
               if (i_rsp_ready) begin
                  r_rr    <= ~r_id;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
